dot_product_sched: RTL and testbench

- Sequencer for the streaming dot-product datapath (DotProductSt).
- On `start`, runs NEURON_N dot products back to back. For each one it clears the datapath, streams PIXEL_N pixel/weight beats from two synchronous-read memories, and waits out the datapath pipeline latency.
- Each captured `value` is handed to a downstream consumer over a valid/ready port.
- Sits between the layer-level control FSM and the datapath/operand memories.

---
 rtl/dp_pkg.sv | 15 +
 rtl/dp_operand_gate.sv | 20 ++
 rtl/dot_product_sched.sv | 98 +++++++++
 tb/tb_dot_product_sched.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// dp_pkg: sequencer state encoding and address-width helpers shared with the datapath and memory wrappers.
package dp_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_FEED   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;
  function automatic int pa_w(int pixel_n);
    return $clog2(pixel_n);
  endfunction
  function automatic int wa_w(int pixel_n, int neuron_n);
    return $clog2(pixel_n * neuron_n);
  endfunction
endpackage

// File: rtl/dp_operand_gate.sv
// dp_operand_gate: forces datapath operands to zero unless a memory read issued last cycle is landing.
module dp_operand_gate import dp_pkg::*; #(
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19
) (
  input  logic                   clk,
  input  logic                   GlobalReset,
  input  logic                   feed,
  input  logic [PIXEL_SIZE-1:0]  pix_data,
  input  logic [WEIGHT_SIZE-1:0] wgt_data,
  output logic [PIXEL_SIZE-1:0]  dp_pixels,
  output logic [WEIGHT_SIZE-1:0] dp_weights
);
  logic feed_d;
  always_ff @(posedge clk or negedge GlobalReset)
    if (!GlobalReset) feed_d <= 1'b0;
    else feed_d <= feed;
  assign dp_pixels  = feed_d ? pix_data : '0;
  assign dp_weights = feed_d ? wgt_data : '0;
endmodule

// File: rtl/dot_product_sched.sv
// dot_product_sched: sequences NEURON_N back-to-back dot products through the streaming datapath
// and hands each result to a downstream consumer over valid/ready.
module dot_product_sched import dp_pkg::*; #(
  parameter int PIXEL_N     = 10,
  parameter int NEURON_N    = 4,
  parameter int WEIGHT_SIZE = 19,
  parameter int PIXEL_SIZE  = 10,
  parameter int VAL_SIZE    = 26,
  parameter int LATENCY     = 8,
  parameter int PA_W        = pa_w(PIXEL_N),
  parameter int WA_W        = wa_w(PIXEL_N, NEURON_N),
  parameter int NI_W        = $clog2(NEURON_N)
) (
  input  logic                   clk,
  input  logic                   GlobalReset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [PA_W-1:0]        pix_addr,
  output logic [WA_W-1:0]        wgt_addr,
  output logic                   mem_rd,
  input  logic [PIXEL_SIZE-1:0]  pix_data,
  input  logic [WEIGHT_SIZE-1:0] wgt_data,
  output logic                   dp_clear,
  output logic [PIXEL_SIZE-1:0]  dp_pixels,
  output logic [WEIGHT_SIZE-1:0] dp_weights,
  input  logic [VAL_SIZE-1:0]    dp_value,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [VAL_SIZE-1:0]    res_data,
  output logic [NI_W-1:0]        res_index
);
  localparam int DW = $clog2(LATENCY + 1);
  logic [2:0]      state;
  logic [PA_W-1:0] b;
  logic [WA_W-1:0] wa;
  logic [DW-1:0]   d;
  logic [NI_W-1:0] n;
  // wa walks n*PIXEL_N+b incrementally since neurons are fed strictly in order
  always_ff @(posedge clk or negedge GlobalReset)
    if (!GlobalReset) begin
      state     <= S_IDLE;
      b         <= '0;
      wa        <= '0;
      d         <= '0;
      n         <= '0;
      res_data  <= '0;
      res_index <= '0;
    end else
      case (state)
        S_IDLE: if (start) begin
          state <= S_CLR;
          n     <= '0;
          wa    <= '0;
        end
        S_CLR: begin
          state <= S_FEED;
          b     <= '0;
        end
        S_FEED: begin
          b  <= b + 1'b1;
          wa <= wa + 1'b1;
          if (b == PA_W'(PIXEL_N - 1)) begin
            state <= S_DRAIN;
            d     <= '0;
          end
        end
        S_DRAIN: begin
          d <= d + 1'b1;
          if (d == DW'(LATENCY)) begin
            res_data  <= dp_value;
            res_index <= n;
            state     <= S_RESULT;
          end
        end
        S_RESULT: if (res_ready) begin
          state <= (n == NI_W'(NEURON_N - 1)) ? S_FIN : S_CLR;
          n     <= (n == NI_W'(NEURON_N - 1)) ? n : n + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
  assign busy      = state != S_IDLE;
  assign done      = state == S_FIN;
  assign mem_rd    = state == S_FEED;
  assign res_valid = state == S_RESULT;
  assign dp_clear  = !GlobalReset || state == S_CLR;
  assign pix_addr  = b;
  assign wgt_addr  = wa;
  dp_operand_gate #(.PIXEL_SIZE(PIXEL_SIZE), .WEIGHT_SIZE(WEIGHT_SIZE)) u_gate (
    .clk(clk),
    .GlobalReset(GlobalReset),
    .feed(mem_rd),
    .pix_data(pix_data),
    .wgt_data(wgt_data),
    .dp_pixels(dp_pixels),
    .dp_weights(dp_weights)
  );
endmodule

// File: tb/tb_dot_product_sched.sv
// tb_dot_product_sched: drives dot_product_sched with behavioural memories and datapath,
// checking results, handshake timing, addressing and operand gating.
module tb_dot_product_sched;
  localparam int P = 10, N = 4, PS = 10, WS = 19, VS = 26, L = 8;
  localparam int PA_W = 4, WA_W = 6, NI_W = 2;
  logic clk = 1'b0;
  logic GlobalReset, start, res_ready;
  logic busy, done, mem_rd, dp_clear, res_valid;
  logic [PA_W-1:0] pix_addr;
  logic [WA_W-1:0] wgt_addr;
  logic [PS-1:0] pix_data, dp_pixels;
  logic [WS-1:0] wgt_data, dp_weights;
  logic [VS-1:0] dp_value, res_data;
  logic [NI_W-1:0] res_index;
  always #5 clk = ~clk;
  dot_product_sched #(.PIXEL_N(P), .NEURON_N(N), .WEIGHT_SIZE(WS), .PIXEL_SIZE(PS),
                      .VAL_SIZE(VS), .LATENCY(L)) dut (
    .clk(clk), .GlobalReset(GlobalReset), .start(start), .busy(busy), .done(done),
    .pix_addr(pix_addr), .wgt_addr(wgt_addr), .mem_rd(mem_rd),
    .pix_data(pix_data), .wgt_data(wgt_data), .dp_clear(dp_clear),
    .dp_pixels(dp_pixels), .dp_weights(dp_weights), .dp_value(dp_value),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_index(res_index)
  );
  logic [PS-1:0] pmem [P];
  logic [WS-1:0] wmem [P*N];
  always @(posedge clk)
    if (mem_rd) begin
      pix_data <= pmem[pix_addr];
      wgt_data <= wmem[wgt_addr];
    end
  // datapath stand-in: accumulate, then a delay line so the sum settles LATENCY cycles after the last operand
  logic [63:0] acc;
  logic [63:0] dl [L-1];
  always @(posedge clk) begin
    acc <= dp_clear ? 64'd0 : acc + 64'(dp_pixels) * 64'(dp_weights);
    dl[0] <= acc;
    for (int i = 1; i < L - 1; i++) dl[i] <= dl[i-1];
  end
  assign dp_value = VS'(dl[L-2] << 2);
  typedef struct {
    logic rnd;
    int stall;
    int wt [N];
    logic [VS-1:0] ex [N];
  } vec_t;
  vec_t vt [6];
  int checks = 0, errors = 0;
  int rd_cnt = 0, base = 0, done_cnt = 0;
  logic prev_rd = 1'b0;
  logic [PA_W-1:0] prev_pa;
  logic [WA_W-1:0] prev_wa;
  logic [NI_W+VS-1:0] got [$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
    if (!GlobalReset) prev_rd = 1'b0;
    else begin
      if (done) done_cnt++;
      if (res_valid && res_ready) got.push_back({res_index, res_data});
      chk("gate_pix", 64'(dp_pixels), prev_rd ? 64'(pmem[prev_pa]) : 64'd0);
      chk("gate_wgt", 64'(dp_weights), prev_rd ? 64'(wmem[prev_wa]) : 64'd0);
      if (mem_rd) begin
        chk("pix_addr", 64'(pix_addr), 64'((rd_cnt - base) % P));
        chk("wgt_addr", 64'(wgt_addr), 64'(rd_cnt - base));
        rd_cnt++;
      end
      prev_rd = mem_rd;
      prev_pa = pix_addr;
      prev_wa = wgt_addr;
    end
  endtask
  function automatic vec_t mk(logic r, int s, int w0, int w1, int w2, int w3);
    vec_t v;
    v.rnd = r;
    v.stall = s;
    v.wt = '{w0, w1, w2, w3};
    for (int k = 0; k < N; k++) v.ex[k] = VS'(45 * v.wt[k]) << 18;
    return v;
  endfunction
  function automatic logic [VS-1:0] ref_dot(int k);
    logic [63:0] s = 64'd0;
    for (int i = 0; i < P; i++) s += 64'(pmem[i]) * 64'(wmem[k*P+i]);
    return VS'(s << 2);
  endfunction
  task automatic load(input vec_t v);
    for (int i = 0; i < P; i++) pmem[i] = v.rnd ? PS'($urandom) : PS'(i);
    for (int k = 0; k < N; k++)
      for (int i = 0; i < P; i++)
        wmem[k*P+i] = v.rnd ? WS'($urandom) : WS'(v.wt[k]) << 16;
  endtask
  task automatic run(input vec_t v);
    logic [VS-1:0] ex [N];
    int t, d0;
    load(v);
    for (int k = 0; k < N; k++) ex[k] = v.rnd ? ref_dot(k) : v.ex[k];
    d0 = done_cnt;
    base = rd_cnt;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    t = 1;
    for (int k = 0; k < N; k++) begin
      while (!res_valid && t < 300) begin tick(); t++; end
      chk("latency", 64'(t), 64'(P + L + 3));
      chk("res_index", 64'(res_index), 64'(k));
      chk("res_data", 64'(res_data), 64'(ex[k]));
      repeat (v.stall) begin
        tick();
        chk("stall_hold", 64'({res_valid, mem_rd, res_index, res_data}),
            64'({1'b1, 1'b0, NI_W'(k), ex[k]}));
      end
      res_ready = 1'b1;
      tick(); res_ready = 1'b0;
      t = 1;
      if (k < N - 1) chk("next_clr", 64'({dp_clear, done, res_valid, busy}), 64'(4'b1001));
      else chk("fin", 64'({dp_clear, done, res_valid, busy}), 64'(4'b0101));
    end
    tick();
    chk("idle", 64'({busy, done, res_valid}), 64'd0);
    chk("done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("rd_cnt", 64'(rd_cnt - base), 64'(P * N));
  endtask
  initial begin
    int t, d0, q0;
    GlobalReset = 1'b0;
    start = 1'b0;
    res_ready = 1'b0;
    vt[0] = mk(1'b0, 0, 1, 1, 1, 1);
    vt[1] = mk(1'b0, 0, 1, 2, 3, 4);
    vt[2] = mk(1'b0, 5, 4, 3, 2, 1);
    for (int i = 3; i < 6; i++) vt[i] = mk(1'b1, int'($urandom_range(0, 6)), 0, 0, 0, 0);
    repeat (3) tick();
    chk("reset_outs", 64'({busy, done, mem_rd, res_valid, pix_addr, wgt_addr, res_index}), 64'd0);
    chk("reset_clear", 64'(dp_clear), 64'd1);
    #2 GlobalReset = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) run(vt[i]);
    // start pulses while busy must not restart or extend the run
    load(vt[0]);
    d0 = done_cnt; base = rd_cnt; q0 = got.size();
    res_ready = 1'b1;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    repeat (5) tick();
    chk("in_feed", 64'(mem_rd), 64'd1);
    start = 1'b1; tick(); start = 1'b0;
    repeat (12) tick();
    chk("in_drain", 64'({busy, mem_rd, res_valid}), 64'(3'b100));
    start = 1'b1; tick(); start = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 400) begin tick(); t++; end
    repeat (30) tick();
    res_ready = 1'b0;
    chk("ign_done", 64'(done_cnt - d0), 64'd1);
    chk("ign_rd", 64'(rd_cnt - base), 64'(P * N));
    chk("ign_results", 64'(got.size() - q0), 64'(N));
    for (int k = 0; k < N && q0 + k < got.size(); k++)
      chk("ign_value", 64'(got[q0+k]), 64'({NI_W'(k), vt[0].ex[k]}));
    // asynchronous reset in the middle of FEED abandons the run
    load(vt[0]);
    base = rd_cnt; d0 = done_cnt;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    repeat (6) tick();
    chk("pre_rst", 64'({mem_rd, pix_addr}), 64'({1'b1, 4'd5}));
    #2 GlobalReset = 1'b0;
    #1;
    chk("rst_outs", 64'({busy, done, mem_rd, res_valid, pix_addr, wgt_addr, res_index}), 64'd0);
    chk("rst_data", 64'({res_data, dp_pixels, dp_weights}), 64'd0);
    chk("rst_clear", 64'(dp_clear), 64'd1);
    tick();
    #2 GlobalReset = 1'b1;
    repeat (40) tick();
    chk("rst_no_done", 64'({busy, 32'(done_cnt - d0)}), 64'd0);
    run(vt[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
